// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// Holds one decoded entry (operands, immediate select, ALU opcode, rd info)
// behind a valid/ready handshake on both sides, with a synchronous flush.
// Build option: define SIGMA_FWD_EN to forward EX/MEM and MEM/WB results onto
// the operand outputs. Without it, the stage stalls decode on read-after-write
// hazards instead.
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_use_imm,
  input  logic [3:0]            in_alu_op,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic                  exmem_reg_write,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
  input  logic                  memwb_reg_write,
  input  logic [XLEN-1:0]       memwb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       operand1,
  output logic [XLEN-1:0]       operand2,
  output logic [3:0]            alu_op,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write
);

  // Held entry
  logic                  valid_q,     valid_d;
  logic [XLEN-1:0]       rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]       imm_q,       imm_d;
  logic                  use_imm_q,   use_imm_d;
  logic [3:0]            alu_op_q,    alu_op_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic                  reg_write_q, reg_write_d;

  logic hazard_stall;
  logic accept;
  logic consume;

`ifdef SIGMA_FWD_EN
  // Source indices are only kept when they are needed for forwarding.
  logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;

  // Youngest producer wins: EX/MEM before MEM/WB, x0 never forwarded.
  function automatic logic [XLEN-1:0] fwd_value(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [XLEN-1:0]       reg_data,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic                  ex_we,
    input logic [XLEN-1:0]       ex_res,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic                  wb_we,
    input logic [XLEN-1:0]       wb_res
  );
    logic [XLEN-1:0] v;
    v = reg_data;
    if (rs != '0) begin
      if (ex_we && (ex_rd == rs))      v = ex_res;
      else if (wb_we && (wb_rd == rs)) v = wb_res;
    end
    return v;
  endfunction

  assign hazard_stall = 1'b0;

  // Forwarded operands; immediate bypasses forwarding on operand2.
  always_comb begin
    operand1 = fwd_value(rs1_addr_q, rs1_data_q, exmem_rd_addr, exmem_reg_write,
                         exmem_result, memwb_rd_addr, memwb_reg_write, memwb_result);
    operand2 = use_imm_q ? imm_q
             : fwd_value(rs2_addr_q, rs2_data_q, exmem_rd_addr, exmem_reg_write,
                         exmem_result, memwb_rd_addr, memwb_reg_write, memwb_result);
  end
`else
  // A nonzero source is blocked while any in-flight writer targets it.
  function automatic logic src_busy(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  held_we,
    input logic [REG_ADDR_W-1:0] held_rd,
    input logic [REG_ADDR_W-1:0] ex_rd,
    input logic                  ex_we,
    input logic [REG_ADDR_W-1:0] wb_rd,
    input logic                  wb_we
  );
    return (rs != '0) &&
           ((held_we && (held_rd == rs)) ||
            (ex_we   && (ex_rd   == rs)) ||
            (wb_we   && (wb_rd   == rs)));
  endfunction

  // Stall decode on a read-after-write dependency that cannot be forwarded.
  always_comb begin
    hazard_stall = in_valid &&
      (src_busy(in_rs1_addr, valid_q && reg_write_q, rd_addr_q,
                exmem_rd_addr, exmem_reg_write, memwb_rd_addr, memwb_reg_write) ||
       (!in_use_imm &&
        src_busy(in_rs2_addr, valid_q && reg_write_q, rd_addr_q,
                 exmem_rd_addr, exmem_reg_write, memwb_rd_addr, memwb_reg_write)));
  end

  // Operands come straight from the registered regfile data.
  always_comb begin
    operand1 = rs1_data_q;
    operand2 = use_imm_q ? imm_q : rs2_data_q;
  end

  // Result buses are only meaningful when forwarding is built in.
  logic unused_ok;
  assign unused_ok = ^{exmem_result, memwb_result};
`endif

  assign in_ready      = !flush && (!valid_q || out_ready) && !hazard_stall;
  assign accept        = in_valid && in_ready;
  assign consume       = valid_q && out_ready;

  assign out_valid     = valid_q;
  assign alu_op        = alu_op_q;
  assign out_rd_addr   = rd_addr_q;
  assign out_reg_write = reg_write_q;

  // Next-state: flush kills, accept captures, consume empties, otherwise hold.
  always_comb begin
    valid_d     = valid_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    use_imm_d   = use_imm_q;
    alu_op_d    = alu_op_q;
    rd_addr_d   = rd_addr_q;
    reg_write_d = reg_write_q;
`ifdef SIGMA_FWD_EN
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
`endif
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d     = 1'b1;
      rs1_data_d  = in_rs1_data;
      rs2_data_d  = in_rs2_data;
      imm_d       = in_imm;
      use_imm_d   = in_use_imm;
      alu_op_d    = in_alu_op;
      rd_addr_d   = in_rd_addr;
      reg_write_d = in_reg_write;
`ifdef SIGMA_FWD_EN
      rs1_addr_d  = in_rs1_addr;
      rs2_addr_d  = in_rs2_addr;
`endif
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_op_q    <= '0;
      rd_addr_q   <= '0;
      reg_write_q <= 1'b0;
`ifdef SIGMA_FWD_EN
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
`endif
    end else begin
      valid_q     <= valid_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      use_imm_q   <= use_imm_d;
      alu_op_q    <= alu_op_d;
      rd_addr_q   <= rd_addr_d;
      reg_write_q <= reg_write_d;
`ifdef SIGMA_FWD_EN
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [RW-1:0]   in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
  logic            in_use_imm, in_reg_write;
  logic [3:0]      in_alu_op;
  logic [RW-1:0]   exmem_rd_addr, memwb_rd_addr;
  logic            exmem_reg_write, memwb_reg_write;
  logic [XLEN-1:0] exmem_result, memwb_result;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] operand1, operand2;
  logic [3:0]      alu_op;
  logic [RW-1:0]   out_rd_addr;
  logic            out_reg_write;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .exmem_rd_addr(exmem_rd_addr), .exmem_reg_write(exmem_reg_write),
    .exmem_result(exmem_result),
    .memwb_rd_addr(memwb_rd_addr), .memwb_reg_write(memwb_reg_write),
    .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .operand1(operand1), .operand2(operand2), .alu_op(alu_op),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: one held instruction record ----------------
  typedef struct {
    logic            valid;
    logic [RW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] d1, d2, imm;
    logic            use_imm, we;
    logic [3:0]      op;
  } entry_t;

  entry_t m;

  // Is register r still awaiting a result from an older instruction?
  function automatic bit pending_write(input logic [RW-1:0] r);
    if (r == 0) return 0;
    if (m.valid && m.we && m.rd == r) return 1;
    if (exmem_reg_write && exmem_rd_addr == r) return 1;
    if (memwb_reg_write && memwb_rd_addr == r) return 1;
    return 0;
  endfunction

  function automatic bit model_stall();
`ifdef SIGMA_FWD_EN
    return 0;
`else
    if (!in_valid) return 0;
    return pending_write(in_rs1_addr) || (!in_use_imm && pending_write(in_rs2_addr));
`endif
  endfunction

  function automatic bit model_ready();
    return !flush && (!m.valid || out_ready) && !model_stall();
  endfunction

  // Value an instruction reading register r should see.
  function automatic logic [XLEN-1:0] reg_value(input logic [RW-1:0] r, input logic [XLEN-1:0] file_data);
`ifdef SIGMA_FWD_EN
    if (r != 0 && exmem_reg_write && exmem_rd_addr == r) return exmem_result;
    if (r != 0 && memwb_reg_write && memwb_rd_addr == r) return memwb_result;
`endif
    return file_data;
  endfunction

  // Advance the model one transaction step per clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '{valid: 1'b0, rs1: '0, rs2: '0, rd: '0, d1: '0, d2: '0, imm: '0,
             use_imm: 1'b0, we: 1'b0, op: '0};
    end else if (flush) begin
      m.valid <= 1'b0;
    end else if (in_valid && model_ready()) begin
      m <= '{valid: 1'b1, rs1: in_rs1_addr, rs2: in_rs2_addr, rd: in_rd_addr,
             d1: in_rs1_data, d2: in_rs2_data, imm: in_imm,
             use_imm: in_use_imm, we: in_reg_write, op: in_alu_op};
    end else if (m.valid && out_ready) begin
      m.valid <= 1'b0;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("in_ready",      {31'd0, in_ready},      {31'd0, model_ready()});
    check("out_valid",     {31'd0, out_valid},     {31'd0, m.valid});
    check("operand1",      operand1,               reg_value(m.rs1, m.d1));
    check("operand2",      operand2,               m.use_imm ? m.imm : reg_value(m.rs2, m.d2));
    check("alu_op",        {28'd0, alu_op},        {28'd0, m.op});
    check("out_rd_addr",   {27'd0, out_rd_addr},   {27'd0, m.rd});
    check("out_reg_write", {31'd0, out_reg_write}, {31'd0, m.we});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_entry(input logic [RW-1:0] rs1, input logic [XLEN-1:0] d1,
                             input logic [RW-1:0] rs2, input logic [XLEN-1:0] d2,
                             input logic [XLEN-1:0] imm, input logic use_imm,
                             input logic [3:0] op, input logic [RW-1:0] rd);
    in_valid    = 1'b1;
    in_rs1_addr = rs1; in_rs1_data = d1;
    in_rs2_addr = rs2; in_rs2_data = d2;
    in_imm      = imm; in_use_imm  = use_imm;
    in_alu_op   = op;  in_rd_addr  = rd; in_reg_write = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_use_imm = 1'b0; in_reg_write = 1'b0; in_alu_op = '0;
    exmem_rd_addr = '0; exmem_reg_write = 1'b0; exmem_result = '0;
    memwb_rd_addr = '0; memwb_reg_write = 1'b0; memwb_result = '0;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_operand1",  operand1, 32'd0);
    check("rst_operand2",  operand2, 32'd0);
    check("rst_alu_op",    {28'd0, alu_op}, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Accept: x5=7, imm=-4 selected
    step();
    drive_entry(5'd5, 32'd7, 5'd6, 32'h99, 32'hFFFF_FFFC, 1'b1, 4'h0, 5'd9);
    out_ready = 1'b1;
    step();
    check("acc_out_valid", {31'd0, out_valid}, 32'd1);
    check("acc_operand1",  operand1, 32'd7);
    check("acc_operand2",  operand2, 32'hFFFF_FFFC);

    // Backpressure for 3 cycles, then swap
    out_ready = 1'b0;
    drive_entry(5'd2, 32'h1111, 5'd3, 32'h2222, 32'h0, 1'b0, 4'h1, 5'd10);
    #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready_hold", {31'd0, in_ready}, 32'd0);
      check("bp_operand1",      operand1, 32'd7);
      check("bp_operand2",      operand2, 32'hFFFF_FFFC);
      check("bp_out_valid",     {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    #1 check("swap_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("swap_out_valid", {31'd0, out_valid}, 32'd1);
    check("swap_operand1",  operand1, 32'h1111);
    check("swap_operand2",  operand2, 32'h2222);
    check("swap_alu_op",    {28'd0, alu_op}, 32'd1);

    // Flush with a would-be accept
    drive_entry(5'd4, 32'h3333, 5'd0, 32'h0, 32'h0, 1'b1, 4'h2, 5'd12);
    flush = 1'b1;
    #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_operand1",  operand1, 32'h1111);
    flush = 1'b0; in_valid = 1'b0;

`ifdef SIGMA_FWD_EN
    // Forwarding priority on held rs1=x3
    drive_entry(5'd3, 32'hAAAA, 5'd0, 32'h0, 32'h0, 1'b1, 4'h0, 5'd11);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    exmem_rd_addr = 5'd3; exmem_reg_write = 1'b1; exmem_result = 32'h10;
    memwb_rd_addr = 5'd3; memwb_reg_write = 1'b1; memwb_result = 32'h20;
    #1 check("fwd_exmem", operand1, 32'h10);
    exmem_reg_write = 1'b0;
    #1 check("fwd_memwb", operand1, 32'h20);
    memwb_reg_write = 1'b0;
    #1 check("fwd_none", operand1, 32'hAAAA);
    out_ready = 1'b1;
    drive_entry(5'd0, 32'h5555, 5'd0, 32'h0, 32'h0, 1'b1, 4'h0, 5'd11);
    exmem_rd_addr = 5'd0; exmem_reg_write = 1'b1; exmem_result = 32'hDEAD;
    step();
    check("fwd_x0", operand1, 32'h5555);
    exmem_reg_write = 1'b0; in_valid = 1'b0;
`else
    // Hazard stall on rs2=x4 pending in MEM/WB
    drive_entry(5'd0, 32'h0, 5'd4, 32'h4444, 32'h0, 1'b0, 4'h3, 5'd11);
    memwb_rd_addr = 5'd4; memwb_reg_write = 1'b1; memwb_result = 32'hBEEF;
    #1 check("haz_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("haz_out_valid", {31'd0, out_valid}, 32'd0);
    memwb_reg_write = 1'b0;
    #1 check("haz_clear_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("haz_cap_valid",    {31'd0, out_valid}, 32'd1);
    check("haz_cap_operand2", operand2, 32'h4444);
    in_valid = 1'b0;
`endif

    // Asynchronous reset while an entry is held
    out_ready = 1'b1;
    drive_entry(5'd7, 32'h7777, 5'd8, 32'h8888, 32'h0, 1'b0, 4'h5, 5'd13);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_operand1",  operand1, 32'd0);
    check("arst_operand2",  operand2, 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      step();
      in_valid        = ($urandom_range(0, 9) < 7);
      out_ready       = ($urandom_range(0, 9) < 7);
      flush           = ($urandom_range(0, 15) == 0);
      in_rs1_addr     = RW'($urandom_range(0, 7));
      in_rs2_addr     = RW'($urandom_range(0, 7));
      in_rd_addr      = RW'($urandom_range(0, 7));
      in_rs1_data     = $urandom;
      in_rs2_data     = $urandom;
      in_imm          = $urandom;
      in_use_imm      = $urandom_range(0, 1) == 1;
      in_reg_write    = $urandom_range(0, 1) == 1;
      in_alu_op       = 4'($urandom_range(0, 15));
      exmem_rd_addr   = RW'($urandom_range(0, 7));
      exmem_reg_write = ($urandom_range(0, 3) == 0);
      exmem_result    = $urandom;
      memwb_rd_addr   = RW'($urandom_range(0, 7));
      memwb_reg_write = ($urandom_range(0, 3) == 0);
      memwb_result    = $urandom;
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
